// File: rtl/regfile_wb_unit.sv
// rtl/regfile_wb_unit.sv - RV32 register file write-back stage with collision buffer and bypassed reads
module regfile_wb_unit #(
    parameter int XLEN = 32,
    parameter int AW   = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    input  logic            alu_wr_en,
    input  logic [AW-1:0]   alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            mem_wr_en,
    input  logic [AW-1:0]   mem_rd,
    input  logic [XLEN-1:0] mem_data,
    output logic            wb_stall,
    output logic            pend_valid,
    output logic            wb_err
);

    localparam int DEPTH = 2 ** AW;

    logic [XLEN-1:0] regArray [DEPTH];
    logic [AW-1:0]   pendRd;
    logic [XLEN-1:0] pendData;
    logic            pendValid;
    logic            errFlag;

    logic            aluEff;
    logic            memEff;
    logic            wrEn;
    logic [AW-1:0]   wrAddr;
    logic [XLEN-1:0] wrData;
    logic            capture;

    assign wb_stall   = pendValid;
    assign pend_valid = pendValid;
    assign wb_err     = errFlag;

    // x0 requests are never effective, so they can neither write nor collide.
    assign aluEff = alu_wr_en && (alu_rd != '0) && !pendValid;
    assign memEff = mem_wr_en && (mem_rd != '0) && !pendValid;

    // Single array write port: drain first, then load (older), then ALU.
    always_comb begin
        wrEn    = 1'b0;
        wrAddr  = '0;
        wrData  = '0;
        capture = 1'b0;
        if (pendValid) begin
            wrEn   = 1'b1;
            wrAddr = pendRd;
            wrData = pendData;
        end else if (memEff) begin
            wrEn    = 1'b1;
            wrAddr  = mem_rd;
            wrData  = mem_data;
            capture = aluEff;
        end else if (aluEff) begin
            wrEn   = 1'b1;
            wrAddr = alu_rd;
            wrData = alu_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regArray[i] <= '0;
            end
            pendValid <= 1'b0;
            pendRd    <= '0;
            pendData  <= '0;
            errFlag   <= 1'b0;
        end else begin
            if (wrEn && (wrAddr != '0)) begin
                regArray[wrAddr] <= wrData;
            end
            if (pendValid) begin
                pendValid <= 1'b0;
                if (alu_wr_en || mem_wr_en) begin
                    errFlag <= 1'b1;
                end
            end else if (capture) begin
                pendValid <= 1'b1;
                pendRd    <= alu_rd;
                pendData  <= alu_data;
            end
        end
    end

    // ALU outranks the load in the bypass since it is the younger instruction.
    always_comb begin
        rs1_data = regArray[rs1_addr];
        if (rs1_addr == '0) begin
            rs1_data = '0;
        end else if (aluEff && (alu_rd == rs1_addr)) begin
            rs1_data = alu_data;
        end else if (memEff && (mem_rd == rs1_addr)) begin
            rs1_data = mem_data;
        end else if (pendValid && (pendRd == rs1_addr)) begin
            rs1_data = pendData;
        end
    end

    always_comb begin
        rs2_data = regArray[rs2_addr];
        if (rs2_addr == '0) begin
            rs2_data = '0;
        end else if (aluEff && (alu_rd == rs2_addr)) begin
            rs2_data = alu_data;
        end else if (memEff && (mem_rd == rs2_addr)) begin
            rs2_data = mem_data;
        end else if (pendValid && (pendRd == rs2_addr)) begin
            rs2_data = pendData;
        end
    end

endmodule

// File: tb/tb_regfile_wb_unit.sv
// tb/tb_regfile_wb_unit.sv - directed and randomized bench for regfile_wb_unit
module tb_regfile_wb_unit;

    logic        clk;
    logic        rst;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        alu_wr_en;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        mem_wr_en;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic        wb_stall;
    logic        pend_valid;
    logic        wb_err;

    int checks = 0;
    int errors = 0;

    regfile_wb_unit #(.XLEN(32), .AW(5)) dut (
        .clk(clk), .rst(rst),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .alu_wr_en(alu_wr_en), .alu_rd(alu_rd), .alu_data(alu_data),
        .mem_wr_en(mem_wr_en), .mem_rd(mem_rd), .mem_data(mem_data),
        .wb_stall(wb_stall), .pend_valid(pend_valid), .wb_err(wb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: architectural registers plus a FIFO of deferred writes.
    logic [31:0] mRegs [32];
    logic [4:0]  qRd [$];
    logic [31:0] qData [$];
    bit          mErr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mRead(input logic [4:0] addr);
        bit stalled = (qRd.size() != 0);
        if (addr == 0) return 32'h0;
        if (!stalled && alu_wr_en && alu_rd != 0 && alu_rd == addr) return alu_data;
        if (!stalled && mem_wr_en && mem_rd != 0 && mem_rd == addr) return mem_data;
        if (stalled && qRd[0] == addr) return qData[0];
        return mRegs[addr];
    endfunction

    task automatic mEdge();
        logic [4:0]  wRd [$];
        logic [31:0] wData [$];
        if (rst) begin
            foreach (mRegs[i]) mRegs[i] = 32'h0;
            qRd.delete();
            qData.delete();
            mErr = 0;
        end else if (qRd.size() != 0) begin
            mRegs[qRd.pop_front()] = qData.pop_front();
            if (alu_wr_en || mem_wr_en) mErr = 1;
        end else begin
            // Age order: load is older than the ALU result.
            if (mem_wr_en && mem_rd != 0) begin wRd.push_back(mem_rd); wData.push_back(mem_data); end
            if (alu_wr_en && alu_rd != 0) begin wRd.push_back(alu_rd); wData.push_back(alu_data); end
            if (wRd.size() != 0) mRegs[wRd.pop_front()] = wData.pop_front();
            while (wRd.size() != 0) begin
                qRd.push_back(wRd.pop_front());
                qData.push_back(wData.pop_front());
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        mEdge();
        @(negedge clk);
    endtask

    task automatic drive(input logic ae, input logic [4:0] ard, input logic [31:0] ad,
                         input logic me, input logic [4:0] mrd, input logic [31:0] md);
        alu_wr_en = ae; alu_rd = ard; alu_data = ad;
        mem_wr_en = me; mem_rd = mrd; mem_data = md;
    endtask

    task automatic checkModel(input string tag);
        #1;
        check({tag, ".rs1"}, rs1_data, mRead(rs1_addr));
        check({tag, ".rs2"}, rs2_data, mRead(rs2_addr));
        check({tag, ".pend"}, {31'h0, pend_valid}, {31'h0, qRd.size() != 0});
        check({tag, ".stall"}, {31'h0, wb_stall}, {31'h0, qRd.size() != 0});
        check({tag, ".err"}, {31'h0, wb_err}, {31'h0, mErr});
    endtask

    initial begin
        rst = 1'b1;
        rs1_addr = 0; rs2_addr = 0;
        drive(0, 0, 0, 0, 0, 0);
        foreach (mRegs[i]) mRegs[i] = 32'h0;
        mErr = 0;
        @(negedge clk);
        tick();
        rst = 1'b0;

        for (int a = 0; a < 32; a++) begin
            rs1_addr = a[4:0]; rs2_addr = 5'(31 - a);
            #1;
            check("reset.rs1", rs1_data, 32'h0);
            check("reset.rs2", rs2_data, 32'h0);
        end
        check("reset.pend", {31'h0, pend_valid}, 32'h0);
        check("reset.stall", {31'h0, wb_stall}, 32'h0);
        check("reset.err", {31'h0, wb_err}, 32'h0);

        drive(1, 5, 32'hDEADBEEF, 0, 0, 0);
        rs1_addr = 5; rs2_addr = 0;
        #1 check("bypass.alu", rs1_data, 32'hDEADBEEF);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        rs2_addr = 5;
        #1 check("array.x5", rs2_data, 32'hDEADBEEF);
        check("single.pend", {31'h0, pend_valid}, 32'h0);

        drive(1, 3, 32'h11, 1, 4, 32'h22);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        rs1_addr = 3; rs2_addr = 4;
        #1;
        check("coll.pend", {31'h0, pend_valid}, 32'h1);
        check("coll.stall", {31'h0, wb_stall}, 32'h1);
        check("coll.x3_pend", rs1_data, 32'h11);
        check("coll.x4", rs2_data, 32'h22);
        tick();
        #1;
        check("drain.pend", {31'h0, pend_valid}, 32'h0);
        check("drain.x3", rs1_data, 32'h11);

        drive(1, 7, 32'hBBBB, 1, 7, 32'hAAAA);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        rs1_addr = 7;
        #1 check("same_rd.mid", rs1_data, 32'hBBBB);
        tick();
        #1 check("same_rd.final", rs1_data, 32'hBBBB);
        check("same_rd.pend", {31'h0, pend_valid}, 32'h0);

        drive(1, 0, 32'hFFFF, 1, 0, 32'h1234);
        rs1_addr = 0;
        #1 check("x0.read", rs1_data, 32'h0);
        check("x0.stall", {31'h0, wb_stall}, 32'h0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        #1 check("x0.pend", {31'h0, pend_valid}, 32'h0);
        check("x0.after", rs1_data, 32'h0);

        drive(1, 9, 32'h99, 1, 10, 32'hA0);
        tick();
        drive(1, 11, 32'h5555, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        rs1_addr = 9; rs2_addr = 11;
        #1;
        check("err.flag", {31'h0, wb_err}, 32'h1);
        check("err.drained", rs1_data, 32'h99);
        check("err.lost", rs2_data, 32'h0);
        check("err.pend", {31'h0, pend_valid}, 32'h0);

        drive(1, 12, 32'h12, 1, 13, 32'h13);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rs1_addr = 12; rs2_addr = 13;
        #1;
        check("rstpend.pend", {31'h0, pend_valid}, 32'h0);
        check("rstpend.err", {31'h0, wb_err}, 32'h0);
        check("rstpend.x12", rs1_data, 32'h0);
        check("rstpend.x13", rs2_data, 32'h0);

        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 99) == 0);
            drive($urandom_range(0, 2) != 0, 5'($urandom_range(0, 7)), $urandom,
                  $urandom_range(0, 2) != 0, 5'($urandom_range(0, 7)), $urandom);
            rs1_addr = 5'($urandom_range(0, 8));
            rs2_addr = 5'($urandom_range(0, 8));
            checkModel("rand");
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
